// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single data memory with a combinational read
// path. Every access takes exactly three cycles:
// IDLE (grant and latch) -> SERVE (drive memory) -> RESP (done pulse).
// When both ports request in the same IDLE cycle, the port that was not
// granted last wins. Misaligned accesses never write memory and complete
// with err=1 and rd=0.
//
// Handshake: a requester raises req together with we/addr/wd and holds all
// four stable until its done pulse. In the cycle after done it either drops
// req or presents a new request. Requests seen in SERVE or RESP are ignored,
// not queued; the requester keeps req high until it is served.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req0/1, we0/1     request and write enable per port
//   addr0/1, wd0/1    byte address and write data per port
//   rd0/1             read data, valid while the matching done is high
//   done0/1           one-cycle completion pulse
//   err0/1            misaligned-address flag, valid while done is high
//   mem_mwr           memory write enable (SERVE only, aligned write)
//   mem_addr, mem_wd  latched address and write data; held outside SERVE
//   mem_rd            memory read data, combinational in mem_addr
//   busy              high whenever the FSM is not in IDLE
//   dbg_state         current FSM state encoding (0 IDLE, 1 SERVE, 2 RESP)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wd0,
   input  logic [DATA_W-1:0] wd1,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic              mem_mwr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic                last_gnt_q;   // port granted most recently
   logic                win_id_q;     // port owning the current access
   logic                lat_we_q;
   logic [ADDR_W-1:0]   lat_addr_q;
   logic [DATA_W-1:0]   lat_wd_q;
   logic [DATA_W-1:0]   rd_q;
   logic                err_q;

   logic                any_req;
   logic                gnt_id;
   logic                aligned;

   assign any_req = req0 | req1;

   // Single requester wins outright; on a tie the port not granted last wins.
   assign gnt_id  = (req0 && req1) ? ~last_gnt_q : req1;

   assign aligned = (lat_addr_q[1:0] == 2'b00);

   // ---------------------------------------------------------------------------
   // State register and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;   // port 0 wins the first tie after reset
         win_id_q   <= 1'b0;
         lat_we_q   <= 1'b0;
         lat_addr_q <= '0;
         lat_wd_q   <= '0;
         rd_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_q == IDLE && any_req) begin
            win_id_q   <= gnt_id;
            last_gnt_q <= gnt_id;
            if (gnt_id) begin
               lat_we_q   <= we1;
               lat_addr_q <= addr1;
               lat_wd_q   <= wd1;
            end else begin
               lat_we_q   <= we0;
               lat_addr_q <= addr0;
               lat_wd_q   <= wd0;
            end
         end

         // Capture the response on the SERVE->RESP edge. Writes and misaligned
         // accesses return zero so rd never leaks stale memory contents.
         if (state_q == SERVE) begin
            rd_q  <= (!lat_we_q && aligned) ? mem_rd : '0;
            err_q <= !aligned;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = SERVE;
         SERVE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      done0     = 1'b0;
      done1     = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      rd0       = '0;
      rd1       = '0;
      mem_mwr   = 1'b0;
      mem_addr  = lat_addr_q;
      mem_wd    = lat_wd_q;
      busy      = (state_q != IDLE);
      dbg_state = state_q;

      case (state_q)
         SERVE: begin
            // rst gates the strobe directly so a reset during SERVE
            // cannot commit a write on the same edge.
            mem_mwr = lat_we_q && aligned && !rst;
         end
         RESP: begin
            if (win_id_q) begin
               done1 = 1'b1;
               rd1   = rd_q;
               err1  = err_q;
            end else begin
               done0 = 1'b1;
               rd0   = rd_q;
               err0  = err_q;
            end
         end
         default: ;
      endcase
   end

endmodule
